// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: sequential req/gnt/rvalid fetches into a DEPTH-entry FIFO feeding decode.
// Latency: rvalid in cycle N -> inst_valid in cycle N+1 (registered FIFO, no bypass).
// Backpressure: stall holds the FIFO head; requests only issue while count+outstanding < DEPTH.
//
// Ports:
//   clk, reset           rising-edge clock; asynchronous active-low reset
//   redirect/_pc         flush the buffer and restart fetch at redirect_pc (word aligned)
//   stall                pipeline not accepting the head instruction this cycle
//   imem_req/addr/gnt    request channel; a request is held until granted (or withdrawn by redirect)
//   imem_rvalid/rdata    in-order response channel
//   inst_valid/inst/pc   FIFO head to the pipeline; inst is a NOP when the buffer is empty
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0]   fetch_pc;
  logic [31:0]   out_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem [DEPTH];

  logic [CW:0] in_use;
  logic        fire;
  logic        rsp;
  logic        push;
  logic        pop;

  // Every in-flight request owns a FIFO slot, so a response can always be pushed.
  // Once raised, this sum only shrinks until a grant, which keeps an ungranted request stable.
  assign in_use   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req = reset && !redirect && (in_use < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign fire     = imem_req && imem_gnt;

  // A response with nothing outstanding is a bus error and is ignored.
  assign rsp  = imem_rvalid && (outstanding != '0);
  // Responses owed to a pre-redirect stream (drop>0), or arriving during a redirect, are discarded.
  assign push = rsp && (drop == '0) && !redirect;
  assign pop  = inst_valid && !stall && !redirect;

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? mem[rd_ptr] : NOP;
  assign inst_pc    = out_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      out_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(rsp);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        out_pc   <= redirect_pc;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        // Everything still in flight after this cycle belongs to the old stream.
        drop     <= outstanding - CW'(rsp);
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (pop) begin
          out_pc <= out_pc + 32'd4;
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (rsp && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= imem_rdata;
  end

  // Bus protocol check: memory must never respond with nothing outstanding.
  rvalid_has_outstanding: assert property (
    @(posedge clk) disable iff (!reset) imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFFFFF8;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction stream as queues of addresses.
  typedef struct {
    logic [31:0] addr;
    int unsigned t;
    bit          stale;
  } fl_t;

  logic [31:0] fifo_q [$];
  fl_t         infl_q [$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_out_pc;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_miscmp = 0;

  // Memory contents: a fixed scramble of the address so misordered words are visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E3779B9;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    infl_q.delete();
    m_fetch_pc = RST_PC;
    m_out_pc   = RST_PC;
  endtask

  // Asserted at a negedge; outputs must take reset values before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; redirect = 1'b0; stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    redirect_pc = 32'h0; imem_rdata = 32'h0;
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, RST_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst",  inst, NOP);
    chk("rst_pc",    inst_pc, RST_PC);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input int unsigned p_red, input int unsigned p_stall,
                      input int unsigned p_gnt, input int unsigned p_rv);
    bit          exp_req;
    bit          fire;
    bit          pre_valid;
    logic [31:0] exp_inst;
    fl_t         e;
    @(negedge clk);
    redirect = ($urandom_range(99) < p_red);
    case ($urandom_range(3))
      0:       redirect_pc = 32'h100;
      1:       redirect_pc = 32'hFFFFFFF4;
      2:       redirect_pc = 32'h0;
      default: redirect_pc = $urandom & 32'hFFFFFFFC;
    endcase
    stall    = ($urandom_range(99) < p_stall);
    imem_gnt = ($urandom_range(99) < p_gnt);
    if (infl_q.size() > 0 && infl_q[0].t < cyc && $urandom_range(99) < p_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(infl_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    exp_req  = !redirect && (fifo_q.size() + infl_q.size() < DEPTH);
    exp_inst = (fifo_q.size() > 0) ? mem_word(fifo_q[0]) : NOP;
    chk("imem_req",   32'(imem_req), 32'(exp_req));
    chk("imem_addr",  imem_addr, m_fetch_pc);
    chk("inst_valid", 32'(inst_valid), 32'(fifo_q.size() > 0));
    chk("inst",       inst, exp_inst);
    chk("inst_pc",    inst_pc, m_out_pc);

    // Advance the model by one clock.
    fire      = exp_req && imem_gnt;
    pre_valid = (fifo_q.size() > 0);
    if (imem_rvalid) begin
      e = infl_q.pop_front();
      if (!e.stale && !redirect) fifo_q.push_back(e.addr);
    end
    if (redirect) begin
      fifo_q.delete();
      foreach (infl_q[i]) infl_q[i].stale = 1'b1;
      m_fetch_pc = redirect_pc;
      m_out_pc   = redirect_pc;
    end else begin
      if (pre_valid && !stall) begin
        void'(fifo_q.pop_front());
        m_out_pc = m_out_pc + 32'd4;
      end
      if (fire) begin
        infl_q.push_back('{addr: m_fetch_pc, t: cyc, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Phases: {redirect%, stall%, gnt%, rvalid%, cycles}
  typedef struct {
    int unsigned red;
    int unsigned stl;
    int unsigned gnt;
    int unsigned rv;
    int unsigned n;
  } phase_t;

  phase_t phases [8] = '{
    '{0,   0, 100, 100,  40},  // full streaming from RESET_PC through the wrap
    '{0, 100, 100, 100,  12},  // held stall: buffer fills, requests stop
    '{0,   0, 100, 100,  20},  // release: one instruction per cycle
    '{0,   0,  30,  80, 150},  // sparse grants: request held stable
    '{5,  30,  70,  60, 800},
    '{25, 20,  90,  90, 600},  // frequent redirects, incl. back-to-back and with responses
    '{2,  60,  90,  40, 600},
    '{10, 10, 100, 100, 400}
  };

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    model_reset();
    for (int round = 0; round < 2; round++) begin
      do_reset();
      foreach (phases[p]) begin
        for (int c = 0; c < int'(phases[p].n); c++)
          step(phases[p].red, phases[p].stl, phases[p].gnt, phases[p].rv);
      end
    end
    // Reset in the middle of traffic, then a short run to confirm a clean restart.
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 30; c++) step(5, 20, 80, 70);
      do_reset();
      for (int c = 0; c < 30; c++) step(0, 0, 100, 100);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
